// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at issue, captures CDB results,
// retires in program order to the register file and raises a one-cycle
// flush with the redirect PC when a mispredicted control transfer retires.
// Tag 0 is reserved as "no dependency"; live tags cycle through 1..ROB_SIZE-1.
module reorder_buffer #(
  parameter int ROB_SIZE  = 16,
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,

  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  output logic                 rob_full,
  output logic [ROB_WIDTH-1:0] rob_next_index,

  input  logic                 cdb_valid,
  input  logic [ROB_WIDTH-1:0] cdb_rob_index,
  input  logic [31:0]          cdb_val,
  input  logic                 cdb_mispredict,
  input  logic [31:0]          cdb_target,

  input  logic [ROB_WIDTH-1:0] query1_index,
  input  logic [ROB_WIDTH-1:0] query2_index,
  output logic                 query1_ready,
  output logic                 query2_ready,
  output logic [31:0]          query1_val,
  output logic [31:0]          query2_val,

  output logic                 rob_to_reg_commit,
  output logic [ROB_WIDTH-1:0] rob_to_reg_rob_index,
  output logic [4:0]           rob_to_reg_index,
  output logic [31:0]          rob_to_reg_val,

  output logic                 rob_flush,
  output logic [31:0]          rob_flush_pc
);

  typedef logic [ROB_WIDTH-1:0] tag_t;

  localparam tag_t FIRST_TAG = ROB_WIDTH'(1);
  localparam tag_t LAST_TAG  = ROB_WIDTH'(ROB_SIZE - 1);

  // Pointers and occupancy
  tag_t head;
  tag_t tail;
  tag_t count;

  // Per-entry status flags (reset) and payload storage (not reset)
  logic [ROB_SIZE-1:0] busy;
  logic [ROB_SIZE-1:0] ready;
  logic [ROB_SIZE-1:0] mispredict;
  logic [4:0]          rd_mem     [ROB_SIZE];
  logic [31:0]         val_mem    [ROB_SIZE];
  logic [31:0]         target_mem [ROB_SIZE];

  logic commit_fire;
  logic flush_fire;
  logic issue_accept;
  logic cdb_hit;

  // Advance a tag, skipping the reserved tag 0 on wrap.
  function automatic tag_t wrap_inc(input tag_t t);
    return (t == LAST_TAG) ? FIRST_TAG : t + ROB_WIDTH'(1);
  endfunction

  // Operand lookup: a result on the CDB this cycle wins over the stored copy.
  function automatic logic [32:0] lookup(input tag_t        idx,
                                         input logic        bus_valid,
                                         input tag_t        bus_idx,
                                         input logic [31:0] bus_val,
                                         input logic        entry_ready,
                                         input logic [31:0] entry_val);
    if (idx == '0)                         return {1'b0, 32'h0};
    else if (bus_valid && bus_idx == idx)  return {1'b1, bus_val};
    else if (entry_ready)                  return {1'b1, entry_val};
    else                                   return {1'b0, 32'h0};
  endfunction

  // Commit looks only at registered flags, so a CDB write to the head entry
  // retires one cycle later rather than being bypassed into this edge.
  assign commit_fire    = busy[head] & ready[head];
  assign flush_fire     = commit_fire & mispredict[head];
  assign rob_full       = (count == LAST_TAG);
  assign rob_next_index = tail;
  assign issue_accept   = issue_valid & ~rob_full & ~flush_fire;
  assign cdb_hit        = cdb_valid & busy[cdb_rob_index];

  assign {query1_ready, query1_val} = lookup(query1_index, cdb_valid, cdb_rob_index, cdb_val,
                                             ready[query1_index], val_mem[query1_index]);
  assign {query2_ready, query2_val} = lookup(query2_index, cdb_valid, cdb_rob_index, cdb_val,
                                             ready[query2_index], val_mem[query2_index]);

  // Control state: pointers, count, entry flags and the registered commit/flush outputs.
  always_ff @(posedge clk_in) begin
    // NOTE: state is updated with non-blocking assignments so every read in this
    // block sees the pre-edge value, regardless of statement order.
    if (rst_in) begin
      head                 <= FIRST_TAG;
      tail                 <= FIRST_TAG;
      count                <= '0;
      busy                 <= '0;
      ready                <= '0;
      mispredict           <= '0;
      rob_to_reg_commit    <= 1'b0;
      rob_to_reg_rob_index <= '0;
      rob_to_reg_index     <= '0;
      rob_to_reg_val       <= '0;
      rob_flush            <= 1'b0;
      rob_flush_pc         <= '0;
    end else if (rdy_in) begin
      rob_to_reg_commit <= commit_fire;
      rob_flush         <= flush_fire;

      if (commit_fire) begin
        rob_to_reg_rob_index <= head;
        rob_to_reg_index     <= rd_mem[head];
        rob_to_reg_val       <= val_mem[head];
      end

      if (flush_fire) begin
        // Mispredict retires: everything younger is squashed, including
        // this cycle's issue and CDB traffic.
        rob_flush_pc <= target_mem[head];
        head         <= FIRST_TAG;
        tail         <= FIRST_TAG;
        count        <= '0;
        busy         <= '0;
        ready        <= '0;
        mispredict   <= '0;
      end else begin
        if (cdb_hit) begin
          ready[cdb_rob_index]      <= 1'b1;
          mispredict[cdb_rob_index] <= cdb_mispredict;
        end
        if (commit_fire) begin
          busy[head]       <= 1'b0;
          ready[head]      <= 1'b0;
          mispredict[head] <= 1'b0;
          head             <= wrap_inc(head);
        end
        if (issue_accept) begin
          busy[tail]       <= 1'b1;
          ready[tail]      <= 1'b0;
          mispredict[tail] <= 1'b0;
          tail             <= wrap_inc(tail);
        end
        count <= count + ROB_WIDTH'(issue_accept) - ROB_WIDTH'(commit_fire);
      end
    end
  end

  // Payload storage: destination register at issue, result and target at CDB.
  always_ff @(posedge clk_in) begin
    // NOTE: payload arrays carry no reset; the busy/ready flags gate every read,
    // so stale contents are never observed and the arrays can map to plain RAM.
    if (rdy_in) begin
      if (issue_accept) begin
        rd_mem[tail] <= issue_rd;
      end
      if (cdb_hit) begin
        val_mem[cdb_rob_index]    <= cdb_val;
        target_mem[cdb_rob_index] <= cdb_target;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: expected retirements are queued when the
// completing CDB result is driven and popped whenever the DUT pulses commit.
module tb_reorder_buffer;

  localparam int ROB_SIZE  = 16;
  localparam int ROB_WIDTH = 4;

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic                 rdy_in;
  logic                 issue_valid;
  logic [4:0]           issue_rd;
  logic                 rob_full;
  logic [ROB_WIDTH-1:0] rob_next_index;
  logic                 cdb_valid;
  logic [ROB_WIDTH-1:0] cdb_rob_index;
  logic [31:0]          cdb_val;
  logic                 cdb_mispredict;
  logic [31:0]          cdb_target;
  logic [ROB_WIDTH-1:0] query1_index;
  logic [ROB_WIDTH-1:0] query2_index;
  logic                 query1_ready;
  logic                 query2_ready;
  logic [31:0]          query1_val;
  logic [31:0]          query2_val;
  logic                 rob_to_reg_commit;
  logic [ROB_WIDTH-1:0] rob_to_reg_rob_index;
  logic [4:0]           rob_to_reg_index;
  logic [31:0]          rob_to_reg_val;
  logic                 rob_flush;
  logic [31:0]          rob_flush_pc;

  typedef struct {
    logic [3:0]  tag;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        flush;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  reorder_buffer #(.ROB_SIZE(ROB_SIZE), .ROB_WIDTH(ROB_WIDTH)) dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .rdy_in               (rdy_in),
    .issue_valid          (issue_valid),
    .issue_rd             (issue_rd),
    .rob_full             (rob_full),
    .rob_next_index       (rob_next_index),
    .cdb_valid            (cdb_valid),
    .cdb_rob_index        (cdb_rob_index),
    .cdb_val              (cdb_val),
    .cdb_mispredict       (cdb_mispredict),
    .cdb_target           (cdb_target),
    .query1_index         (query1_index),
    .query2_index         (query2_index),
    .query1_ready         (query1_ready),
    .query2_ready         (query2_ready),
    .query1_val           (query1_val),
    .query2_val           (query2_val),
    .rob_to_reg_commit    (rob_to_reg_commit),
    .rob_to_reg_rob_index (rob_to_reg_rob_index),
    .rob_to_reg_index     (rob_to_reg_index),
    .rob_to_reg_val       (rob_to_reg_val),
    .rob_flush            (rob_flush),
    .rob_flush_pc         (rob_flush_pc)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic expect_commit(input logic [3:0] tag, input logic [4:0] rd, input logic [31:0] val,
                               input logic flush, input logic [31:0] pc);
    exp_t e;
    e.tag = tag; e.rd = rd; e.val = val; e.flush = flush; e.pc = pc;
    sb.push_back(e);
  endtask

  // One clock; outputs sampled 1 time unit after the edge, commits scoreboarded.
  task automatic step();
    exp_t e;
    @(posedge clk_in);
    #1;
    if (rob_to_reg_commit) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("commit_tag", 32'(rob_to_reg_rob_index), 32'(e.tag));
        check("commit_rd", 32'(rob_to_reg_index), 32'(e.rd));
        check("commit_val", rob_to_reg_val, e.val);
        check("commit_flush", 32'(rob_flush), 32'(e.flush));
        if (e.flush) check("commit_flush_pc", rob_flush_pc, e.pc);
      end
    end else begin
      check("flush_without_commit", 32'(rob_flush), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1;
    issue_valid = 1'b0; issue_rd = '0;
    cdb_valid = 1'b0; cdb_rob_index = '0; cdb_val = '0; cdb_mispredict = 1'b0; cdb_target = '0;
    query1_index = '0; query2_index = '0;
    step(); step();
    rst_in = 1'b0;

    // Reset state
    check("reset_full", 32'(rob_full), 0);
    check("reset_next_index", 32'(rob_next_index), 1);
    check("reset_commit", 32'(rob_to_reg_commit), 0);
    check("reset_flush", 32'(rob_flush), 0);
    check("reset_flush_pc", rob_flush_pc, 0);
    check("reset_commit_val", rob_to_reg_val, 0);

    // In-order retirement of out-of-order completions
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(5 + i);
      check("t1_issue_tag", 32'(rob_next_index), 32'(i + 1));
      step();
    end
    issue_valid = 1'b0;
    cdb_valid = 1'b1; cdb_rob_index = 4'd2; cdb_val = 32'hA;
    step();
    cdb_rob_index = 4'd1; cdb_val = 32'hB;
    expect_commit(4'd1, 5'd5, 32'hB, 1'b0, 32'h0);
    expect_commit(4'd2, 5'd6, 32'hA, 1'b0, 32'h0);
    step();
    check("t1_no_bypass_commit", 32'(rob_to_reg_commit), 0);
    cdb_valid = 1'b0;
    step();
    check("t1_commit_first", 32'(rob_to_reg_commit), 1);
    step();
    check("t1_commit_second", 32'(rob_to_reg_commit), 1);
    step();
    check("t1_tag3_waits", 32'(rob_to_reg_commit), 0);

    // Fill to capacity, reject overflow, wrap tail to 1
    rst_in = 1'b1; step(); rst_in = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i);
      step();
    end
    check("t2_full", 32'(rob_full), 1);
    check("t2_next_wrapped", 32'(rob_next_index), 1);
    issue_rd = 5'd20;
    step();
    check("t2_overflow_full", 32'(rob_full), 1);
    check("t2_overflow_next", 32'(rob_next_index), 1);
    cdb_valid = 1'b1; cdb_rob_index = 4'd1; cdb_val = 32'h111;
    expect_commit(4'd1, 5'd1, 32'h111, 1'b0, 32'h0);
    step();
    check("t2_still_full", 32'(rob_full), 1);
    cdb_rob_index = 4'd2; cdb_val = 32'h222;
    expect_commit(4'd2, 5'd2, 32'h222, 1'b0, 32'h0);
    step();
    check("t2_commit_head", 32'(rob_to_reg_commit), 1);
    check("t2_slot_freed", 32'(rob_full), 0);
    check("t2_next_after_free", 32'(rob_next_index), 1);
    cdb_valid = 1'b0; issue_rd = 5'd21;
    step();
    check("t2_issue_with_commit", 32'(rob_to_reg_commit), 1);
    check("t2_count_held", 32'(rob_full), 0);
    check("t2_next_tag2", 32'(rob_next_index), 2);
    issue_rd = 5'd22;
    step();
    check("t2_full_again", 32'(rob_full), 1);
    check("t2_next_tag3", 32'(rob_next_index), 3);
    issue_valid = 1'b0;

    // Mispredict flush
    rst_in = 1'b1; step(); rst_in = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i);
      step();
    end
    issue_valid = 1'b0;
    cdb_valid = 1'b1; cdb_rob_index = 4'd1; cdb_val = 32'h44; cdb_mispredict = 1'b1; cdb_target = 32'h80;
    expect_commit(4'd1, 5'd1, 32'h44, 1'b1, 32'h80);
    step();
    check("t3_no_flush_yet", 32'(rob_flush), 0);
    cdb_rob_index = 4'd3; cdb_val = 32'h33; cdb_mispredict = 1'b0; cdb_target = 32'h0;
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    check("t3_flush", 32'(rob_flush), 1);
    check("t3_flush_pc", rob_flush_pc, 32'h80);
    check("t3_commit_pulse", 32'(rob_to_reg_commit), 1);
    check("t3_empty_full", 32'(rob_full), 0);
    check("t3_next_index", 32'(rob_next_index), 1);
    issue_valid = 1'b0;
    step();
    check("t3_flush_one_cycle", 32'(rob_flush), 0);
    check("t3_no_commit", 32'(rob_to_reg_commit), 0);
    cdb_valid = 1'b0; query1_index = 4'd3;
    #1;
    check("t3_late_cdb_ignored", 32'(query1_ready), 0);
    query1_index = '0;
    issue_valid = 1'b1; issue_rd = 5'd10;
    step();
    issue_valid = 1'b0;
    check("t3_reissue_tag1", 32'(rob_next_index), 2);

    // Global enable freeze
    cdb_valid = 1'b1; cdb_rob_index = 4'd1; cdb_val = 32'h55;
    step();
    cdb_valid = 1'b0;
    rdy_in = 1'b0; issue_valid = 1'b1; issue_rd = 5'd11;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_frozen_commit", 32'(rob_to_reg_commit), 0);
      check("t4_frozen_next", 32'(rob_next_index), 2);
      check("t4_frozen_pc", rob_flush_pc, 32'h80);
    end
    rdy_in = 1'b1; issue_valid = 1'b0;
    expect_commit(4'd1, 5'd10, 32'h55, 1'b0, 32'h0);
    step();
    check("t4_commit_after_enable", 32'(rob_to_reg_commit), 1);

    // Query bypass and stored read; tags 2..6 allocated
    for (int i = 1; i <= 5; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i);
      step();
    end
    issue_valid = 1'b0;
    query1_index = 4'd4; query2_index = 4'd5;
    cdb_valid = 1'b1; cdb_rob_index = 4'd4; cdb_val = 32'h1234;
    #1;
    check("t5_bypass_ready", 32'(query1_ready), 1);
    check("t5_bypass_val", query1_val, 32'h1234);
    check("t5_pending_ready", 32'(query2_ready), 0);
    check("t5_pending_val", query2_val, 0);
    step();
    cdb_valid = 1'b0;
    #1;
    check("t5_stored_ready", 32'(query1_ready), 1);
    check("t5_stored_val", query1_val, 32'h1234);
    query2_index = '0;
    #1;
    check("t5_tag0_ready", 32'(query2_ready), 0);
    cdb_valid = 1'b1; cdb_rob_index = 4'd9; cdb_val = 32'h99;
    step();
    cdb_valid = 1'b0; query2_index = 4'd9;
    #1;
    check("t5_idle_cdb_ignored", 32'(query2_ready), 0);

    // Reset mid-operation with 5 busy entries, issue asserted
    rst_in = 1'b1; issue_valid = 1'b1; issue_rd = 5'd3;
    step();
    rst_in = 1'b0; issue_valid = 1'b0;
    check("t6_next_index", 32'(rob_next_index), 1);
    check("t6_full", 32'(rob_full), 0);
    check("t6_commit", 32'(rob_to_reg_commit), 0);
    check("t6_commit_tag", 32'(rob_to_reg_rob_index), 0);
    check("t6_commit_rd", 32'(rob_to_reg_index), 0);
    check("t6_commit_val", rob_to_reg_val, 0);
    check("t6_flush", 32'(rob_flush), 0);
    check("t6_flush_pc", rob_flush_pc, 0);
    check("t6_query_cleared", 32'(query1_ready), 0);
    step();
    check("t6_empty_no_commit", 32'(rob_to_reg_commit), 0);

    check("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
